// File: rtl/chkmon_pkg.sv
// chkmon_pkg: shared types and sizing helpers for the checkbits sequence monitor.
//   chkmon_state_t      - monitor FSM states (IDLE, ARMED, PASS, FAIL)
//   stage_width(n)      - width of the stage counter for n stages, $clog2(n)+1
//   presc_width(d)      - width of a prescaler counting 0..d-1
//   DEFAULT_TICK_DIV, DEFAULT_PRESC_W - prescaler sizing for the default divider
package chkmon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } chkmon_state_t;

  function automatic int stage_width(input int num_stages);
    return $clog2(num_stages) + 1;
  endfunction

  function automatic int presc_width(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

  localparam int DEFAULT_TICK_DIV = 1000;
  localparam int DEFAULT_PRESC_W  = presc_width(DEFAULT_TICK_DIV);

endpackage

// File: rtl/chkmon_stable_filter.sv
// chkmon_stable_filter: glitch filter for the monitored checkbits bus.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   restart     - re-arm: the current input is treated as already seen
//   din         - sampled bus
//   stable_evt  - one-cycle pulse when a new value has been seen STABLE_CYCLES
//                 consecutive edges (registered on the STABLE_CYCLES-th edge)
//   stable_val  - value accompanying stable_evt
module chkmon_stable_filter #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [WIDTH-1:0] din,
  output logic             stable_evt,
  output logic [WIDTH-1:0] stable_val
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] sample;
  logic [RUN_W-1:0] run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample     <= '0;
      run        <= '0;
      stable_evt <= 1'b0;
      stable_val <= '0;
    end else begin
      stable_val <= din;
      if (restart) begin
        // Saturating the run here means a value already present at arm time
        // must change away and come back before it can fire.
        sample     <= din;
        run        <= RUN_MAX;
        stable_evt <= 1'b0;
      end else if (din != sample) begin
        sample     <= din;
        run        <= RUN_W'(1);
        stable_evt <= (STABLE_CYCLES == 1);
      end else begin
        if (run != RUN_MAX) run <= run + 1'b1;
        stable_evt <= (run == RUN_MAX - 1'b1);
      end
    end
  end

endmodule

// File: rtl/checkbits_seq_monitor.sv
// checkbits_seq_monitor: steps through NUM_STAGES expected checkbits codes in
// order, with glitch filtering and a prescaled timeout.
// Ports:
//   wb_clk_i, wb_rst_i - clock, asynchronous active-high reset
//   start_i            - arm / re-arm pulse (restarts from stage 0)
//   checkbits_i        - monitored bus
//   exp_codes_i        - stage k code at [k*CHK_WIDTH +: CHK_WIDTH]
//   busy_o, pass_o, fail_o, timeout_o - status (pass/fail sticky until re-arm)
//   stage_o            - stages matched so far
//   stage_hit_o        - one-cycle pulse per stage match
//   elapsed_o          - saturating tick count since arm
// Optional: define CHKMON_STRICT_ORDER_EN to fail when a later stage's code
// is seen before the current one (skipped checkpoint).
module checkbits_seq_monitor
  import chkmon_pkg::*;
#(
  parameter int CHK_WIDTH     = 16,
  parameter int NUM_STAGES    = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TICK_DIV      = 1000,
  parameter int TIMEOUT_TICKS = 200,
  parameter int TICK_W        = 16
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic                                  start_i,
  input  logic [CHK_WIDTH-1:0]                  checkbits_i,
  input  logic [NUM_STAGES*CHK_WIDTH-1:0]       exp_codes_i,
  output logic                                  busy_o,
  output logic                                  pass_o,
  output logic                                  fail_o,
  output logic                                  timeout_o,
  output logic [stage_width(NUM_STAGES)-1:0]    stage_o,
  output logic                                  stage_hit_o,
  output logic [TICK_W-1:0]                     elapsed_o
);

  localparam int SW = stage_width(NUM_STAGES);
  localparam int PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  chkmon_state_t state;
  logic [PW-1:0] presc;

  logic                 evt;
  logic [CHK_WIDTH-1:0] val;

  chkmon_stable_filter #(
    .WIDTH        (CHK_WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .restart   (start_i),
    .din       (checkbits_i),
    .stable_evt(evt),
    .stable_val(val)
  );

  logic [CHK_WIDTH-1:0] cur_code;
  logic                 skip_hit;
  logic                 tick;
  logic [TICK_W-1:0]    elapsed_nxt;
  logic                 timed_out;

  always_comb begin
    cur_code = '0;
    skip_hit = 1'b0;
    for (int unsigned j = 0; j < NUM_STAGES; j++) begin
      if (SW'(j) == stage_o) cur_code = exp_codes_i[j*CHK_WIDTH +: CHK_WIDTH];
    end
`ifdef CHKMON_STRICT_ORDER_EN
    for (int unsigned j = 0; j < NUM_STAGES; j++) begin
      if (SW'(j) > stage_o && exp_codes_i[j*CHK_WIDTH +: CHK_WIDTH] == val)
        skip_hit = 1'b1;
    end
`endif
  end

  always_comb begin
    tick        = (state == ARMED) && (presc == PRESC_LAST);
    elapsed_nxt = elapsed_o;
    if (tick && elapsed_o != '1) elapsed_nxt = elapsed_o + 1'b1;
    // Judged on the next elapsed value so the timeout lands on the tick edge.
    timed_out = (TIMEOUT_TICKS != 0) && (elapsed_nxt == TICK_W'(TIMEOUT_TICKS));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      presc       <= '0;
      busy_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      timeout_o   <= 1'b0;
      stage_o     <= '0;
      stage_hit_o <= 1'b0;
      elapsed_o   <= '0;
    end else begin
      stage_hit_o <= 1'b0;
      if (start_i) begin
        state     <= ARMED;
        presc     <= '0;
        busy_o    <= 1'b1;
        pass_o    <= 1'b0;
        fail_o    <= 1'b0;
        timeout_o <= 1'b0;
        stage_o   <= '0;
        elapsed_o <= '0;
      end else begin
        case (state)
          ARMED: begin
            presc     <= tick ? '0 : presc + 1'b1;
            elapsed_o <= elapsed_nxt;
            if (evt && val == cur_code) begin
              stage_hit_o <= 1'b1;
              stage_o     <= stage_o + 1'b1;
              if (stage_o == LAST_STAGE) begin
                state  <= PASS;
                busy_o <= 1'b0;
                pass_o <= 1'b1;
              end else if (timed_out) begin
                state     <= FAIL;
                busy_o    <= 1'b0;
                fail_o    <= 1'b1;
                timeout_o <= 1'b1;
              end
            end else if (evt && skip_hit) begin
              state  <= FAIL;
              busy_o <= 1'b0;
              fail_o <= 1'b1;
            end else if (timed_out) begin
              state     <= FAIL;
              busy_o    <= 1'b0;
              fail_o    <= 1'b1;
              timeout_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// Testbench for checkbits_seq_monitor: directed scenarios on three instances
// (defaults, short timeout, three stages).
module tb_checkbits_seq_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0: defaults
  logic        start0 = 1'b0;
  logic [15:0] cb0 = '0;
  logic [31:0] exp0 = {16'hAB61, 16'hAB60};
  logic        busy0, pass0, fail0, to0, hit0;
  logic [1:0]  stage0;
  logic [15:0] el0;

  // dut1: TICK_DIV=10, TIMEOUT_TICKS=5
  logic        start1 = 1'b0;
  logic [15:0] cb1 = '0;
  logic        busy1, pass1, fail1, to1, hit1;
  logic [1:0]  stage1;
  logic [15:0] el1;

  // dut2: three stages
  logic        start2 = 1'b0;
  logic [15:0] cb2 = '0;
  logic [47:0] exp2 = {16'hAB62, 16'hAB61, 16'hAB60};
  logic        busy2, pass2, fail2, to2, hit2;
  logic [2:0]  stage2;
  logic [15:0] el2;

  checkbits_seq_monitor dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start0), .checkbits_i(cb0),
    .exp_codes_i(exp0), .busy_o(busy0), .pass_o(pass0), .fail_o(fail0),
    .timeout_o(to0), .stage_o(stage0), .stage_hit_o(hit0), .elapsed_o(el0));

  checkbits_seq_monitor #(.TICK_DIV(10), .TIMEOUT_TICKS(5)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start1), .checkbits_i(cb1),
    .exp_codes_i(exp0), .busy_o(busy1), .pass_o(pass1), .fail_o(fail1),
    .timeout_o(to1), .stage_o(stage1), .stage_hit_o(hit1), .elapsed_o(el1));

  checkbits_seq_monitor #(.NUM_STAGES(3)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start2), .checkbits_i(cb2),
    .exp_codes_i(exp2), .busy_o(busy2), .pass_o(pass2), .fail_o(fail2),
    .timeout_o(to2), .stage_o(stage2), .stage_hit_o(hit2), .elapsed_o(el2));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({busy0, pass0, fail0, to0, hit0} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {busy0, pass0, fail0, to0, hit0});
    end
    checks++;
    if (stage0 !== 2'd0 || el0 !== 16'd0) begin
      errors++; $display("FAIL reset_counters: stage %0d elapsed %0d expected 0 0", stage0, el0);
    end
    checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0 || fail1 !== 1'b0 || fail2 !== 1'b0) begin
      errors++; $display("FAIL reset_others: busy1 %b busy2 %b fail1 %b fail2 %b expected 0", busy1, busy2, fail1, fail2);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sequence();
    cb0 = 16'h0000;
    step();
    start0 = 1'b1; step(); start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL seq_armed: busy got %b expected 1", busy0); end
    cb0 = 16'hAB60;
    for (int e = 1; e <= 16; e++) begin
      if (e == 11) cb0 = 16'hAB61;
      step();
      checks++;
      if (hit0 !== (e == 5 || e == 15)) begin
        errors++; $display("FAIL seq_hit_e%0d: got %b expected %b", e, hit0, (e == 5 || e == 15));
      end
      if (e == 5) begin
        checks++;
        if (stage0 !== 2'd1) begin errors++; $display("FAIL seq_stage1: got %0d expected 1", stage0); end
      end
      if (e == 14) begin
        checks++;
        if (pass0 !== 1'b0 || busy0 !== 1'b1) begin
          errors++; $display("FAIL seq_not_yet: pass %b busy %b expected 0 1", pass0, busy0);
        end
      end
    end
    checks++;
    if (stage0 !== 2'd2 || pass0 !== 1'b1 || busy0 !== 1'b0 || fail0 !== 1'b0) begin
      errors++; $display("FAIL seq_pass: stage %0d pass %b busy %b fail %b expected 2 1 0 0", stage0, pass0, busy0, fail0);
    end
  endtask

  task automatic test_glitch();
    cb0 = 16'h0000;
    step();
    start0 = 1'b1; step(); start0 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      cb0 = (e == 4) ? 16'h0000 : 16'hAB60;
      step();
      checks++;
      if (hit0 !== (e == 9)) begin
        errors++; $display("FAIL glitch_hit_e%0d: got %b expected %b", e, hit0, (e == 9));
      end
    end
    checks++;
    if (stage0 !== 2'd1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL glitch_stage: stage %0d busy %b expected 1 1", stage0, busy0);
    end
  endtask

  task automatic test_start_collision();
    int hits;
    cb0 = 16'h0000;
    step();
    start0 = 1'b1; step(); start0 = 1'b0;
    cb0 = 16'hAB60;
    for (int e = 1; e <= 4; e++) step();
    start0 = 1'b1; step(); start0 = 1'b0;
    checks++;
    if (hit0 !== 1'b0 || stage0 !== 2'd0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL start_wins: hit %b stage %0d busy %b expected 0 0 1", hit0, stage0, busy0);
    end
    hits = 0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (hit0 === 1'b1) hits++;
    end
    checks++;
    if (hits !== 0 || stage0 !== 2'd0) begin
      errors++; $display("FAIL held_no_refire: hits %0d stage %0d expected 0 0", hits, stage0);
    end
  endtask

  task automatic test_timeout();
    cb1 = 16'h0000;
    step();
    start1 = 1'b1; step(); start1 = 1'b0;
    cb1 = 16'hAB60;
    for (int e = 1; e <= 50; e++) begin
      step();
      if (e == 5) begin
        checks++;
        if (stage1 !== 2'd1) begin errors++; $display("FAIL to_stage1: got %0d expected 1", stage1); end
      end
      if (e == 49) begin
        checks++;
        if (fail1 !== 1'b0 || busy1 !== 1'b1 || el1 !== 16'd4) begin
          errors++; $display("FAIL to_before: fail %b busy %b elapsed %0d expected 0 1 4", fail1, busy1, el1);
        end
      end
    end
    checks++;
    if (fail1 !== 1'b1 || to1 !== 1'b1 || el1 !== 16'd5 || busy1 !== 1'b0 || pass1 !== 1'b0) begin
      errors++; $display("FAIL to_fire: fail %b timeout %b elapsed %0d busy %b pass %b expected 1 1 5 0 0", fail1, to1, el1, busy1, pass1);
    end
    checks++;
    if (stage1 !== 2'd1) begin errors++; $display("FAIL to_stage_kept: got %0d expected 1", stage1); end
  endtask

  task automatic test_collision();
    cb1 = 16'h0000;
    step();
    start1 = 1'b1; step(); start1 = 1'b0;
    checks++;
    if (fail1 !== 1'b0 || to1 !== 1'b0 || el1 !== 16'd0) begin
      errors++; $display("FAIL rearm_clear: fail %b timeout %b elapsed %0d expected 0 0 0", fail1, to1, el1);
    end
    cb1 = 16'hAB60;
    for (int e = 1; e <= 50; e++) begin
      if (e == 46) cb1 = 16'hAB61;
      step();
      if (e == 49) begin
        checks++;
        if (pass1 !== 1'b0 || fail1 !== 1'b0 || stage1 !== 2'd1) begin
          errors++; $display("FAIL coll_before: pass %b fail %b stage %0d expected 0 0 1", pass1, fail1, stage1);
        end
      end
    end
    checks++;
    if (pass1 !== 1'b1 || fail1 !== 1'b0 || to1 !== 1'b0 || stage1 !== 2'd2 || hit1 !== 1'b1) begin
      errors++; $display("FAIL coll_pass_wins: pass %b fail %b timeout %b stage %0d hit %b expected 1 0 0 2 1", pass1, fail1, to1, stage1, hit1);
    end
  endtask

  task automatic test_strict();
    int hits;
    cb2 = 16'h0000;
    step();
    start2 = 1'b1; step(); start2 = 1'b0;
    cb2 = 16'hAB62;
    hits = 0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (hit2 === 1'b1) hits++;
      if (e == 4) begin
        checks++;
        if (fail2 !== 1'b0) begin errors++; $display("FAIL strict_early: fail got %b expected 0", fail2); end
      end
    end
    checks++;
    if (hits !== 0 || stage2 !== 3'd0) begin
      errors++; $display("FAIL strict_stage: hits %0d stage %0d expected 0 0", hits, stage2);
    end
`ifdef CHKMON_STRICT_ORDER_EN
    checks++;
    if (fail2 !== 1'b1 || to2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL strict_skip: fail %b timeout %b busy %b expected 1 0 0", fail2, to2, busy2);
    end
`else
    checks++;
    if (fail2 !== 1'b0 || busy2 !== 1'b1 || pass2 !== 1'b0) begin
      errors++; $display("FAIL lax_skip: fail %b busy %b pass %b expected 0 1 0", fail2, busy2, pass2);
    end
`endif
  endtask

  task automatic test_async_reset();
    int hits;
    cb0 = 16'h0000;
    step();
    start0 = 1'b1; step(); start0 = 1'b0;
    cb0 = 16'hAB60;
    for (int e = 1; e <= 5; e++) step();
    checks++;
    if (stage0 !== 2'd1) begin errors++; $display("FAIL ar_pre_stage: got %0d expected 1", stage0); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy0, pass0, fail0, to0, hit0} !== 5'b0 || stage0 !== 2'd0 || el0 !== 16'd0) begin
      errors++; $display("FAIL ar_async: flags %b stage %0d elapsed %0d expected 00000 0 0", {busy0, pass0, fail0, to0, hit0}, stage0, el0);
    end
    step();
    rst = 1'b0;
    step();
    start0 = 1'b1; step(); start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || stage0 !== 2'd0) begin
      errors++; $display("FAIL ar_rearm: busy %b stage %0d expected 1 0", busy0, stage0);
    end
    hits = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (hit0 === 1'b1) hits++;
    end
    checks++;
    if (hits !== 0 || stage0 !== 2'd0) begin
      errors++; $display("FAIL ar_prestable: hits %0d stage %0d expected 0 0", hits, stage0);
    end
    cb0 = 16'h0000;
    step();
    cb0 = 16'hAB60;
    for (int e = 1; e <= 5; e++) step();
    checks++;
    if (stage0 !== 2'd1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL ar_restage: stage %0d busy %b expected 1 1", stage0, busy0);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_glitch();
    test_start_collision();
    test_timeout();
    test_collision();
    test_strict();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
